// File: rtl/inst_enc_if.sv
// Field-bundle in / encoded-word out handshake bundle for inst_encoder.
interface inst_enc_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_opc;
  logic [2:0]        in_f3;
  logic [6:0]        in_f7;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              addr_load;
  logic [ADDR_W-1:0] addr_val;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_ir;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;

  modport master (
    output in_valid, in_opc, in_f3, in_f7, in_rd, in_rs1, in_rs2, in_imm,
    output addr_load, addr_val, out_ready,
    input  in_ready, out_valid, out_ir, out_addr, out_err
  );

  modport slave (
    input  in_valid, in_opc, in_f3, in_f7, in_rd, in_rs1, in_rs2, in_imm,
    input  addr_load, addr_val, out_ready,
    output in_ready, out_valid, out_ir, out_addr, out_err
  );
endinterface

// File: rtl/inst_encoder.sv
// Two-stage RV32I field-to-word encoder with IMEM word-address counter.
// Optional immediate range checking: define INST_ENC_RANGE_CHECK_EN.
module inst_encoder #(
  parameter int ADDR_W = 10
) (
  input  logic       clk,
  input  logic       rst,
  inst_enc_if.slave  bus
);
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_FUNC1 = 7'b0010011;
  localparam logic [6:0] OP_FUNC2 = 7'b0110011;

  logic              r_s1_full, r_s2_full;
  logic [6:0]        r_opc;
  logic [2:0]        r_f3;
  logic [6:0]        r_f7;
  logic [4:0]        r_rd, r_rs1, r_rs2;
  logic [31:0]       r_imm;
  logic [31:0]       r_ir;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr, r_cnt;

  logic              w_s2_en, w_s1_mv, w_in_fire, w_out_fire, w_shift;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic [31:0]       w_ir;
  logic              w_unk, w_rng;

  // S2 can take a word when empty or when its current word leaves this cycle
  assign w_s2_en    = !r_s2_full || bus.out_ready;
  assign w_s1_mv    = r_s1_full && w_s2_en;
  assign w_out_fire = r_s2_full && bus.out_ready;
  assign w_in_fire  = bus.in_valid && bus.in_ready;
  assign w_shift    = (r_f3 == 3'b001) || (r_f3 == 3'b101);

  // Loaded base beats the increment; a word entering S2 this edge sees the new value
  assign w_cnt_nxt = bus.addr_load ? bus.addr_val
                   : (w_out_fire ? r_cnt + 1'b1 : r_cnt);

  assign bus.in_ready  = !r_s1_full || w_s2_en;
  assign bus.out_valid = r_s2_full;
  assign bus.out_ir    = r_ir;
  assign bus.out_addr  = r_addr;
  assign bus.out_err   = r_err;

  always_comb begin
    w_ir  = 32'h0000_0013;
    w_unk = 1'b0;
    case (r_opc)
      OP_LUI, OP_AUIPC: w_ir = {r_imm[31:12], r_rd, r_opc};
      OP_JAL:   w_ir = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12], r_rd, r_opc};
      OP_JALR, OP_LOAD: w_ir = {r_imm[11:0], r_rs1, r_f3, r_rd, r_opc};
      OP_FUNC1: w_ir = w_shift ? {r_f7, r_imm[4:0], r_rs1, r_f3, r_rd, r_opc}
                               : {r_imm[11:0], r_rs1, r_f3, r_rd, r_opc};
      OP_BR:    w_ir = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, r_f3, r_imm[4:1], r_imm[11], r_opc};
      OP_STORE: w_ir = {r_imm[11:5], r_rs2, r_rs1, r_f3, r_imm[4:0], r_opc};
      OP_FUNC2: w_ir = {r_f7, r_rs2, r_rs1, r_f3, r_rd, r_opc};
      default: begin
        w_ir  = 32'h0000_0013;
        w_unk = 1'b1;
      end
    endcase
  end

`ifdef INST_ENC_RANGE_CHECK_EN
  // Immediate must survive truncation to the format's field unchanged
  always_comb begin
    w_rng = 1'b0;
    case (r_opc)
      OP_LUI, OP_AUIPC:          w_rng = |r_imm[11:0];
      OP_JAL:                    w_rng = (r_imm[31:20] != {12{r_imm[20]}}) || r_imm[0];
      OP_JALR, OP_LOAD, OP_STORE: w_rng = r_imm[31:12] != {20{r_imm[11]}};
      OP_FUNC1:                  w_rng = w_shift ? |r_imm[31:5]
                                                 : (r_imm[31:12] != {20{r_imm[11]}});
      OP_BR:                     w_rng = (r_imm[31:13] != {19{r_imm[12]}}) || r_imm[0];
      default:                   w_rng = 1'b0;
    endcase
  end
`else
  assign w_rng = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_full <= 1'b0;
      r_s2_full <= 1'b0;
      r_opc     <= '0;
      r_f3      <= '0;
      r_f7      <= '0;
      r_rd      <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_imm     <= '0;
      r_ir      <= '0;
      r_err     <= 1'b0;
      r_addr    <= '0;
      r_cnt     <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_in_fire) begin
        r_s1_full <= 1'b1;
        r_opc     <= bus.in_opc;
        r_f3      <= bus.in_f3;
        r_f7      <= bus.in_f7;
        r_rd      <= bus.in_rd;
        r_rs1     <= bus.in_rs1;
        r_rs2     <= bus.in_rs2;
        r_imm     <= bus.in_imm;
      end else if (w_s1_mv) begin
        r_s1_full <= 1'b0;
      end
      if (w_s2_en) begin
        r_s2_full <= r_s1_full;
        if (r_s1_full) begin
          r_ir   <= w_ir;
          r_err  <= w_unk | w_rng;
          r_addr <= w_cnt_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_inst_encoder.sv
// Randomized + directed bench for inst_encoder against a field-arithmetic reference model.
module tb_inst_encoder;
  localparam int AW = 10;
`ifdef INST_ENC_RANGE_CHECK_EN
  localparam bit RNG_EN = 1'b1;
`else
  localparam bit RNG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_enc_if #(.ADDR_W(AW)) bus ();
  inst_encoder #(.ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;
  logic [32:0]   exp_q[$];
  logic [AW-1:0] exp_addr = '0;
  bit            rnd_done;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {err, word} built from field values by shifting/masking integers
  function automatic logic [32:0] model(input logic [6:0] opc, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [31:0] imm);
    logic [31:0] w, base_rs, lo;
    int si;
    bit rng, known;
    si = $signed(imm);
    rng = 0; known = 1;
    lo = (32'(rd) << 7) | 32'(opc);
    base_rs = (32'(rs1) << 15) | (32'(f3) << 12);
    case (opc)
      7'h37, 7'h17: begin
        w = (imm & 32'hFFFF_F000) | lo;
        rng = (imm % 4096) != 0;
      end
      7'h6F: begin
        w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
            (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | lo;
        rng = si < -1048576 || si > 1048575 || imm[0];
      end
      7'h13, 7'h03, 7'h67: begin
        if (opc == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
          w = (32'(f7) << 25) | ((imm & 31) << 20) | base_rs | lo;
          rng = imm > 31;
        end else begin
          w = ((imm & 32'hFFF) << 20) | base_rs | lo;
          rng = si < -2048 || si > 2047;
        end
      end
      7'h23: begin
        w = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | base_rs |
            ((imm & 31) << 7) | 32'(opc);
        rng = si < -2048 || si > 2047;
      end
      7'h63: begin
        w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
            (32'(rs2) << 20) | base_rs | (((imm >> 1) & 15) << 8) |
            (((imm >> 11) & 1) << 7) | 32'(opc);
        rng = si < -4096 || si > 4095 || imm[0];
      end
      7'h33: w = (32'(f7) << 25) | (32'(rs2) << 20) | base_rs | lo;
      default: begin
        w = 32'h13;
        known = 0;
      end
    endcase
    return {!known || (RNG_EN && rng), w};
  endfunction

  // Called just after a rising edge; returns just after the accepting edge
  task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [31:0] imm, input logic [31:0] eir, input logic eerr);
    int n = 0;
    bus.in_opc = opc; bus.in_f3 = f3; bus.in_f7 = f7;
    bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_imm = imm;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 300) begin
        chk("in_ready_timeout", 0, 1);
        break;
      end
    end
    if (bus.in_ready) exp_q.push_back({eerr, eir});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_rnd();
    logic [6:0] opcs [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                              7'h23, 7'h13, 7'h33, 7'h7F, 7'h0F};
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd, rs1, rs2;
    logic [31:0] imm;
    logic [32:0] e;
    opc = opcs[$urandom_range(0, 10)];
    f3 = 3'($urandom); f7 = 7'($urandom);
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    case ($urandom_range(0, 3))
      0: imm = $urandom;
      1: imm = 32'($urandom_range(0, 31));
      2: imm = 32'($signed(12'($urandom)));
      default: imm = 32'($signed(13'($urandom)) & ~32'd1);
    endcase
    e = model(opc, f3, f7, rd, rs1, rs2, imm);
    send(opc, f3, f7, rd, rs1, rs2, imm, e[31:0], e[32]);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk("drain_empty", 64'(exp_q.size()), 0);
    @(posedge clk); #1;
  endtask

  // Output monitor: scoreboard pop, address tracking, hold-stable under stall
  logic        prev_stall = 1'b0;
  logic [31:0] prev_ir;
  logic [AW-1:0] prev_addr;
  logic        prev_err;
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst) begin
      exp_q.delete();
      exp_addr = '0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_ir", bus.out_ir, prev_ir);
        chk("stall_addr", bus.out_addr, prev_addr);
        chk("stall_err", bus.out_err, prev_err);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("ir", bus.out_ir, e[31:0]);
          chk("err", bus.out_err, e[32]);
          chk("addr", bus.out_addr, exp_addr);
        end
        exp_addr = exp_addr + 1'b1;
      end
      if (bus.addr_load) exp_addr = bus.addr_val;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_ir = bus.out_ir; prev_addr = bus.out_addr; prev_err = bus.out_err;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 0; bus.in_opc = 0; bus.in_f3 = 0; bus.in_f7 = 0;
    bus.in_rd = 0; bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_imm = 0;
    bus.addr_load = 0; bus.addr_val = 0; bus.out_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_ir", bus.out_ir, 0);
    chk("rst_out_addr", bus.out_addr, 0);
    chk("rst_out_err", bus.out_err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // addi/add/sw sequence with latency check on the first word
    send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
    @(negedge clk);
    chk("lat_after_n", bus.out_valid, 0);
    @(negedge clk);
    chk("lat_after_n1", bus.out_valid, 1);
    @(posedge clk); #1;
    send(7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3, 1'b0);
    send(7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_A423, 1'b0);
    drain();

    send(7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0);
    send(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 32'h0080_00EF, 1'b0);
    send(7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h8000_0093, RNG_EN);
    send(7'h7F, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h0000_0013, 1'b1);
    drain();

    // Two words buffered under stall must drop in_ready
    bus.out_ready = 1'b0;
    send_rnd();
    send_rnd();
    @(negedge clk);
    chk("in_ready_full", bus.in_ready, 0);
    @(posedge clk); #1;

    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) send_rnd();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    drain();

    // Wrap from the top address
    bus.addr_load = 1'b1; bus.addr_val = '1;
    @(posedge clk); #1;
    bus.addr_load = 1'b0;
    for (int i = 0; i < 3; i++) send_rnd();
    drain();

    // Load coinciding with an output transfer: loaded value wins
    bus.out_ready = 1'b0;
    send_rnd();
    @(posedge clk); #1;
    bus.out_ready = 1'b1; bus.addr_load = 1'b1; bus.addr_val = AW'(37);
    @(posedge clk); #1;
    bus.addr_load = 1'b0;
    send_rnd();
    drain();

    // Reset with two words in flight
    bus.out_ready = 1'b0;
    send_rnd();
    send_rnd();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_addr", bus.out_addr, 0);
    chk("midrst_out_ir", bus.out_ir, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
